// File: rtl/cache_pkg.sv
// +----------------------------------------------------------------+
// | cache_pkg: shared types and sizing helpers for cache_set_tracker |
// | Rev 1.0                                                          |
// +----------------------------------------------------------------+
`default_nettype none

package cache_pkg;

  localparam int DEFAULT_IDX_W = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_t;

  // The count must represent 0..2**idx_w inclusive, hence one extra bit.
  function automatic int count_width(input int idx_w);
    return idx_w + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/onehot_decoder.sv
// +----------------------------------------------------------------+
// | onehot_decoder: combinational index to one-hot vector            |
// | Rev 1.0                                                          |
// +----------------------------------------------------------------+
`default_nettype none

module onehot_decoder
  import cache_pkg::*;
#(
  parameter int IDX_W = DEFAULT_IDX_W
) (
  input  logic [IDX_W-1:0]      index,
  output logic [(1<<IDX_W)-1:0] onehot
);

  always_comb begin
    onehot        = '0;
    onehot[index] = 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/cache_set_tracker.sv
// +----------------------------------------------------------------+
// | cache_set_tracker: registered set select, per-set valid bits,    |
// | fill/invalidate, counted flush and valid-line count. Rev 1.0     |
// +----------------------------------------------------------------+
`default_nettype none

module cache_set_tracker
  import cache_pkg::*;
#(
  parameter int IDX_W = DEFAULT_IDX_W,
  parameter int SETS  = 1 << IDX_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [IDX_W-1:0]               req_index,
  output logic                           sel_valid,
  output logic [SETS-1:0]                line_sel,
  output logic                           line_valid,
  input  logic                           fill_en,
  input  logic [IDX_W-1:0]               fill_index,
  input  logic                           inv_en,
  input  logic [IDX_W-1:0]               inv_index,
  input  logic                           flush_start,
  output logic                           flush_busy,
  output logic                           flush_done,
  output logic [count_width(IDX_W)-1:0]  valid_count
);

  localparam int CNT_W = count_width(IDX_W);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [SETS-1:0]    valid_q, valid_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               sel_valid_q;
  logic               line_valid_q;
  logic [SETS-1:0]    line_sel_q;
  logic [SETS-1:0]    dec_onehot;
  logic               accept;
  logic               fill_rise;
  logic               inv_fall;

  onehot_decoder #(
    .IDX_W (IDX_W)
  ) u_dec (
    .index  (req_index),
    .onehot (dec_onehot)
  );

  assign req_ready  = (state_q == IDLE);
  assign flush_busy = (state_q != IDLE);
  assign flush_done = (state_q == DONE);
  assign accept     = req_valid && req_ready;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    valid_d   = valid_q;
    count_d   = count_q;
    fill_rise = 1'b0;
    inv_fall  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A same-index invalidate overrides the fill, so that fill cannot count as a rise.
        fill_rise = fill_en && !valid_q[fill_index]
                    && !(inv_en && (inv_index == fill_index));
        inv_fall  = inv_en && valid_q[inv_index];
        if (fill_en) valid_d[fill_index] = 1'b1;
        if (inv_en)  valid_d[inv_index]  = 1'b0;
        count_d = count_q + CNT_W'(fill_rise) - CNT_W'(inv_fall);
        if (flush_start) begin
          state_d = FLUSH;
          ptr_d   = '0;
        end
      end
      FLUSH: begin
        valid_d[ptr_q] = 1'b0;
        if (valid_q[ptr_q]) count_d = count_q - CNT_W'(1);
        ptr_d = ptr_q + IDX_W'(1);
        if (&ptr_q) state_d = DONE;
      end
      DONE: begin
        count_d = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      valid_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Lookup pipeline samples the array before this edge's fill/invalidate/flush update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_valid_q  <= 1'b0;
      line_sel_q   <= '0;
      line_valid_q <= 1'b0;
    end else begin
      sel_valid_q  <= accept;
      line_sel_q   <= accept ? dec_onehot : '0;
      line_valid_q <= accept && valid_q[req_index];
    end
  end

  assign sel_valid   = sel_valid_q;
  assign line_sel    = line_sel_q;
  assign line_valid  = line_valid_q;
  assign valid_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_cache_set_tracker.sv
// +----------------------------------------------------------------+
// | tb_cache_set_tracker: randomized + directed bench with model     |
// | Rev 1.0                                                          |
// +----------------------------------------------------------------+
`default_nettype none

module tb_cache_set_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [5:0]  req_index;
  logic        sel_valid;
  logic [63:0] line_sel;
  logic        line_valid;
  logic        fill_en, inv_en, flush_start;
  logic [5:0]  fill_index, inv_index;
  logic        flush_busy, flush_done;
  logic [6:0]  valid_count;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  bit done_seen = 1'b0;

  cache_set_tracker #(.IDX_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_index   (req_index),
    .sel_valid   (sel_valid),
    .line_sel    (line_sel),
    .line_valid  (line_valid),
    .fill_en     (fill_en),
    .fill_index  (fill_index),
    .inv_en      (inv_en),
    .inv_index   (inv_index),
    .flush_start (flush_start),
    .flush_busy  (flush_busy),
    .flush_done  (flush_done),
    .valid_count (valid_count)
  );

  always #5 clk = ~clk;

  // Model: set of valid lines, plus a flush cycle number (0 idle, 1..64 clearing set n-1, 65 done).
  bit          mv [64];
  int          fc;
  bit          e_sv;
  logic [63:0] e_sel;
  bit          e_lv;

  function automatic int popc();
    int s = 0;
    foreach (mv[i]) s += int'(mv[i]);
    return s;
  endfunction

  function automatic void model_reset();
    foreach (mv[i]) mv[i] = 1'b0;
    fc = 0; e_sv = 1'b0; e_sel = '0; e_lv = 1'b0;
  endfunction

  always @(posedge clk) begin
    if (rst !== 1'b1) begin
      bit acc;
      acc   = req_valid && (fc == 0);
      e_sv  = acc;
      e_sel = acc ? (64'd1 << req_index) : 64'd0;
      e_lv  = acc && mv[req_index];
      if (fc == 0) begin
        if (fill_en) mv[fill_index] = 1'b1;
        if (inv_en)  mv[inv_index]  = 1'b0;
        if (flush_start) fc = 1;
      end else if (fc <= 64) begin
        mv[fc-1] = 1'b0;
        fc++;
      end else begin
        fc = 0;
      end
    end
  end

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (flush_done === 1'b1) done_seen = 1'b1;
    if (chk_en) begin
      chk("sel_valid",   64'(sel_valid),   64'(e_sv));
      chk("line_sel",    line_sel,         e_sel);
      chk("line_valid",  64'(line_valid),  64'(e_lv));
      chk("req_ready",   64'(req_ready),   64'(fc == 0));
      chk("flush_busy",  64'(flush_busy),  64'(fc != 0));
      chk("flush_done",  64'(flush_done),  64'(fc == 65));
      chk("valid_count", 64'(valid_count), 64'(popc()));
    end
  end

  task automatic cyc(input bit rv, input int ri, input bit fe, input int fi,
                     input bit ie, input int ii, input bit fs);
    req_valid = rv; req_index = 6'(ri);
    fill_en = fe;   fill_index = 6'(fi);
    inv_en = ie;    inv_index = 6'(ii);
    flush_start = fs;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk("rst_count", 64'(valid_count), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int busy_cycles, done_cycle;
    rst = 1'b1;
    model_reset();
    req_valid = 0; req_index = 0; fill_en = 0; fill_index = 0;
    inv_en = 0; inv_index = 0; flush_start = 0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Lookup of 5 right after reset
    cyc(1, 5, 0, 0, 0, 0, 0);
    chk("lit_s1_sel_valid", 64'(sel_valid), 64'd1);
    chk("lit_s1_line_sel", line_sel, 64'h20);
    chk("lit_s1_line_valid", 64'(line_valid), 64'd0);
    chk("lit_s1_ready", 64'(req_ready), 64'd1);

    // Fill 0, 63, 17 then look up 63
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 63, 0, 0, 0);
    cyc(0, 0, 1, 17, 0, 0, 0);
    cyc(1, 63, 0, 0, 0, 0, 0);
    chk("lit_s2_line_valid", 64'(line_valid), 64'd1);
    chk("lit_s2_line_sel", line_sel, 64'h8000000000000000);
    chk("lit_s2_count", 64'(valid_count), 64'd3);

    // Fill+inv same index, then double fill
    cyc(0, 0, 1, 9, 1, 9, 0);
    cyc(1, 9, 0, 0, 0, 0, 0);
    chk("lit_s3_fillinv_lv", 64'(line_valid), 64'd0);
    chk("lit_s3_fillinv_count", 64'(valid_count), 64'd3);
    cyc(0, 0, 1, 9, 0, 0, 0);
    cyc(0, 0, 1, 9, 0, 0, 0);
    chk("lit_s3_dblfill_count", 64'(valid_count), 64'd4);
    cyc(0, 0, 0, 0, 1, 9, 0);
    chk("lit_s3_inv_count", 64'(valid_count), 64'd3);

    // Whole-cache flush with count 3
    cyc(0, 0, 0, 0, 0, 0, 1);
    busy_cycles = 0; done_cycle = 0;
    for (int i = 1; i <= 100 && flush_busy; i++) begin
      busy_cycles++;
      if (flush_done) done_cycle = i;
      idle_cyc();
    end
    chk("lit_s4_busy_cycles", 64'(busy_cycles), 64'd65);
    chk("lit_s4_done_cycle", 64'(done_cycle), 64'd65);
    chk("lit_s4_count", 64'(valid_count), 64'd0);
    for (int k = 0; k < 64; k += 21) begin
      cyc(1, k, 0, 0, 0, 0, 0);
      chk("lit_s4_lookup_lv", 64'(line_valid), 64'd0);
    end

    // Reset in the middle of a flush
    cyc(0, 0, 1, 4, 0, 0, 0);
    chk("lit_s5_count", 64'(valid_count), 64'd1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    done_seen = 1'b0;
    for (int i = 1; i < 20; i++) cyc(0, 0, 0, 0, 1, $urandom_range(0, 63), 0);
    #2;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk("lit_s5_busy", 64'(flush_busy), 64'd0);
    chk("lit_s5_ready", 64'(req_ready), 64'd1);
    chk("lit_s5_count", 64'(valid_count), 64'd0);
    rst = 1'b0;
    repeat (70) idle_cyc();
    chk("lit_s5_no_done", 64'(done_seen), 64'd0);

    // Back-to-back walking lookups, each preceded by a fill of the same set
    do_reset();
    for (int k = 0; k <= 64; k++) begin
      cyc(k > 0, k - 1, k < 64, k, 0, 0, 0);
      if (k > 0) begin
        chk("lit_s6_line_sel", line_sel, 64'd1 << (k - 1));
        chk("lit_s6_line_valid", 64'(line_valid), 64'd1);
      end
    end
    chk("lit_s6_count", 64'(valid_count), 64'd64);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int fi;
      fi = $urandom_range(0, 63);
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 63),
          $urandom_range(0, 2) == 0, fi,
          $urandom_range(0, 2) == 0,
          ($urandom_range(0, 3) == 0) ? fi : $urandom_range(0, 63),
          $urandom_range(0, 149) == 0);
      if (n % 1000 == 999) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cache_set_tracker.md
# cache_set_tracker

Parametrised successor to the fixed 6-to-64 set decoder: turns a cache index into a registered one-hot set-select vector and also keeps the per-set valid bits. It sits between the cache controller and the tag/data arrays. It adds a handshaked lookup port, single-set fill and invalidate, a counted whole-cache flush sequencer, and a running count of valid lines.

## Interface
- IDX_W, default 6: index width.
- SETS, default 1<<IDX_W: number of sets; fixed to 2**IDX_W.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  lookup request.
- req_ready  out  1  lookup accepted. Equals ~flush_busy.
- req_index  in  IDX_W  lookup index.
- sel_valid  out  1  line_sel/line_valid are valid this cycle.
- line_sel  out  SETS  registered one-hot select for the accepted index.
- line_valid  out  1  valid bit of the looked-up set, sampled before same-cycle updates.
- fill_en  in  1  mark fill_index valid.
- fill_index  in  IDX_W  set being filled.
- inv_en  in  1  clear inv_index.
- inv_index  in  IDX_W  set being invalidated.
- flush_start  in  1  begin whole-cache invalidate.
- flush_busy  out  1  flush in progress.
- flush_done  out  1  one-cycle pulse when the flush completes.
- valid_count  out  IDX_W+1  number of valid sets, 0..SETS.

## Operation
- Valid array: SETS flops, all 0 on reset.
- Lookup:
  - Accepted when req_valid && req_ready.
  - Next cycle: sel_valid=1, line_sel=1<<req_index, and line_valid = valid[req_index] as it was in the accept cycle.
  - Without an accept, sel_valid=0 and line_sel=0.
- Fill/invalidate, IDLE state only:
  - fill_en sets the bit; inv_en clears it.
  - When both target the same index in the same cycle, invalidate wins. The bit ends at 0.
  - When they target different indices, both take effect.
  - fill_en and inv_en are ignored while flush_busy.
- valid_count:
  - Updated in the same edge as the array.
  - +1 only on a 0→1 transition; -1 only on a 1→0 transition.
  - Fill and invalidate of different sets in one cycle combine, giving a net change of -1, 0 or +1.
  - Fill of an already-valid set, or invalidate of an invalid set, leaves the count unchanged.
- FSM states IDLE, FLUSH, DONE:
  - IDLE→FLUSH on flush_start. The pointer is loaded with 0.
  - In FLUSH, valid[ptr] is cleared each cycle and ptr increments. At ptr==SETS-1 the state goes to DONE.
  - DONE asserts flush_done for one cycle, forces valid_count to 0 and returns to IDLE.
  - flush_start in FLUSH or DONE is ignored.
  - flush_start together with fill/inv in IDLE: the fill/inv is applied in that cycle and the flush starts.
- A lookup accepted in the same cycle as flush_start completes normally on the next cycle. No lookup is accepted during FLUSH or DONE.
- Reset mid-flush: the block returns immediately to IDLE, with the array cleared, count 0 and no flush_done pulse.

## Timing
- Reset values:
  - sel_valid, line_sel, line_valid, flush_busy, flush_done and valid_count are 0.
  - req_ready is 1.
  - State is IDLE and ptr is 0.
- Lookup latency: 1 cycle, fully pipelined, one lookup per cycle.
- Fill/invalidate effect is visible to a lookup accepted in the following cycle.
- flush_busy is high from the cycle after flush_start through the DONE cycle, SETS+1 cycles in total. flush_done is high in the last of those cycles.
- req_ready is combinational from the state and has no dependency on req_valid.

## Structure
- Package cache_pkg holds:
  - the default IDX_W;
  - the state enum {IDLE, FLUSH, DONE};
  - a function that computes the count width.
- Sub-module onehot_decoder #(IDX_W): purely combinational index→one-hot. It replaces the hand-listed decoder and is instantiated for line_sel.
- The top level contains the valid array, the count, the FSM and the pipeline register.

## Test plan
All scenarios use IDX_W=6.
- Reset, then a lookup of index 5 → the next cycle has sel_valid=1, line_sel=64'h20, line_valid=0, req_ready=1.
- Fill sets 0, 63 and 17, then look up 63 → line_valid=1, line_sel=64'h8000000000000000, valid_count=3.
- Same cycle: fill 9 and inv 9 → bit 9=0, count unchanged. Fill 9 twice → count increases by 1 only.
- With count=3, flush_start → req_ready=0 for 65 cycles, flush_done pulses in cycle 65, after which count=0 and every lookup returns line_valid=0.
- Fill 4, assert inv_en during FLUSH, then reset at flush cycle 20 → the block is in IDLE next cycle, count=0 and flush_done is never seen.
- Back-to-back lookups 0,1,2,…,63 with a fill of index k in the cycle before the lookup of k → line_sel walks the one-hot pattern and each line_valid=1.
